full_comparator: RTL and testbench

// - Magnitude comparator for two WIDTH-bit operands used by the processor datapath (branch/compare unit).
// - Produces combinational EQ/GT flags plus a registered, clocked copy (eq_q/gt_q/lt_q) for pipelined consumers.
// - Implemented as a log2(WIDTH)-level tree of 2-bit compare cells (each cell emits local eq/gt), merged MSB-first.

---
 rtl/full_comparator_if.sv | 23 ++
 rtl/full_comparator.sv | 64 ++++++
 tb/tb_full_comparator.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/full_comparator_if.sv
// Operand/flag bundle for the datapath magnitude comparator.
// The comparator sits on the slave side, and the operand producer sits on the master side.
interface full_comparator_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             EQ;
  logic             GT;
  logic             eq_q;
  logic             gt_q;
  logic             lt_q;

  modport master (
    output A, B,
    input  EQ, GT, eq_q, gt_q, lt_q
  );

  modport slave (
    input  A, B,
    output EQ, GT, eq_q, gt_q, lt_q
  );
endinterface

// File: rtl/full_comparator.sv
// WIDTH-bit magnitude comparator built as a tree of 2-bit compare cells.
// It drives combinational EQ/GT and a registered eq_q/gt_q/lt_q stage.
module full_comparator #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          SIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  full_comparator_if.slave  cmp
);

  localparam int unsigned LEAVES = WIDTH / 2;
  localparam int unsigned NODES  = WIDTH - 1;

  logic [NODES-1:0] eq_n;
  logic [NODES-1:0] gt_n;
  logic [1:0]       a2;
  logic [1:0]       b2;
  int unsigned      n;

  // Heap-ordered tree: node i has hi child 2i+1 and lo child 2i+2, and the root is node 0.
  // Leaves occupy LEAVES-1..NODES-1, with the most significant bit pair leftmost.
  // Merges are evaluated from the bottom up so that children settle before their parents.
  always_comb begin
    eq_n = '0;
    gt_n = '0;
    a2   = '0;
    b2   = '0;
    n    = 0;
    for (int unsigned j = 0; j < LEAVES; j++) begin
      a2 = cmp.A[WIDTH-1-2*j -: 2];
      b2 = cmp.B[WIDTH-1-2*j -: 2];
      if (SIGNED && j == 0) begin
        a2[1] = ~a2[1];
        b2[1] = ~b2[1];
      end
      eq_n[LEAVES-1+j] = (a2 == b2);
      gt_n[LEAVES-1+j] = (a2 > b2);
    end
    for (int unsigned k = 0; k < LEAVES - 1; k++) begin
      n       = LEAVES - 2 - k;
      eq_n[n] = eq_n[2*n+1] & eq_n[2*n+2];
      gt_n[n] = gt_n[2*n+1] | (eq_n[2*n+1] & gt_n[2*n+2]);
    end
  end

  always_comb begin
    cmp.EQ = eq_n[0];
    cmp.GT = gt_n[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp.eq_q <= 1'b0;
      cmp.gt_q <= 1'b0;
      cmp.lt_q <= 1'b0;
    end else begin
      cmp.eq_q <= cmp.EQ;
      cmp.gt_q <= cmp.GT;
      cmp.lt_q <= ~cmp.EQ & ~cmp.GT;
    end
  end

endmodule

// File: tb/tb_full_comparator.sv
// Random and directed bench for full_comparator.
// Unsigned and signed instances run side by side against an arithmetic reference.
module tb_full_comparator;

  localparam int unsigned W = 32;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  full_comparator_if #(.WIDTH(W)) if_u ();
  full_comparator_if #(.WIDTH(W)) if_s ();

  full_comparator #(.WIDTH(W), .SIGNED(1'b0)) dut_u (
    .clk   (clk),
    .rst_n (rst_n),
    .cmp   (if_u)
  );

  full_comparator #(.WIDTH(W), .SIGNED(1'b1)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .cmp   (if_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b);
    if_u.A = a;
    if_u.B = b;
    if_s.A = a;
    if_s.B = b;
  endtask

  task automatic check_comb(input logic [W-1:0] a, input logic [W-1:0] b);
    check("u_EQ", if_u.EQ, a == b);
    check("u_GT", if_u.GT, a > b);
    check("s_EQ", if_s.EQ, a == b);
    check("s_GT", if_s.GT, $signed(a) > $signed(b));
  endtask

  task automatic check_regs(input logic [W-1:0] a, input logic [W-1:0] b);
    check("u_eq_q", if_u.eq_q, a == b);
    check("u_gt_q", if_u.gt_q, a > b);
    check("u_lt_q", if_u.lt_q, a < b);
    check("s_eq_q", if_s.eq_q, a == b);
    check("s_gt_q", if_s.gt_q, $signed(a) > $signed(b));
    check("s_lt_q", if_s.lt_q, $signed(a) < $signed(b));
    check("u_onehot", $countones({if_u.eq_q, if_u.gt_q, if_u.lt_q}) == 1, 1'b1);
    check("s_onehot", $countones({if_s.eq_q, if_s.gt_q, if_s.lt_q}) == 1, 1'b1);
  endtask

  task automatic check_regs_zero(input string tag);
    check({tag, "_u_eq_q"}, if_u.eq_q, 1'b0);
    check({tag, "_u_gt_q"}, if_u.gt_q, 1'b0);
    check({tag, "_u_lt_q"}, if_u.lt_q, 1'b0);
    check({tag, "_s_eq_q"}, if_s.eq_q, 1'b0);
    check({tag, "_s_gt_q"}, if_s.gt_q, 1'b0);
    check({tag, "_s_lt_q"}, if_s.lt_q, 1'b0);
  endtask

  // Inputs change on falling edges, so each rising edge samples a settled pair.
  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    drive(a, b);
    #1;
    check_comb(a, b);
    @(posedge clk);
    #1;
    check_regs(a, b);
  endtask

  logic [W-1:0] dir_a [10];
  logic [W-1:0] dir_b [10];

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    n_checks = 0;
    n_fails  = 0;
    rst_n    = 1'b0;
    drive(32'd19, 32'd15);

    dir_a = '{32'd15, 32'd19, 32'hDEADBEEF, 32'd1, 32'h8000_0000,
              32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5679, 32'h7FFF_FFFF};
    dir_b = '{32'd19, 32'd15, 32'hDEADBEEF, 32'd0, 32'h7FFF_FFFF,
              32'd0, 32'hFFFF_FFFF, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF};

    // Registers hold zero in reset across clock edges while the comb path stays live.
    repeat (2) @(posedge clk);
    #1;
    check_regs_zero("rst");
    check_comb(32'd19, 32'd15);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_regs_zero("prefirst");
    @(posedge clk);
    #1;
    check_regs(32'd19, 32'd15);

    for (int i = 0; i < 10; i++) apply(dir_a[i], dir_b[i]);

    // Reset asserted mid-cycle with A > B drops the flops at once and leaves EQ/GT untouched.
    apply(32'd19, 32'd15);
    #2;
    rst_n = 1'b0;
    #1;
    check_regs_zero("async");
    check_comb(32'd19, 32'd15);
    @(posedge clk);
    #1;
    check_regs_zero("hold");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_u_gt_q", if_u.gt_q, 1'b1);
    check("rel_s_gt_q", if_s.gt_q, 1'b1);
    check_regs(32'd19, 32'd15);

    for (int i = 0; i < 10000; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(9))
        0: rb = ra;
        1: rb = ra ^ (32'd1 << $urandom_range(W - 1));
        default: ;
      endcase
      apply(ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
